rvga_xalu: RTL and testbench
============================

// Module: rvga_xalu
// PURPOSE
//  Parametrised, handshaked execute unit for the rvga core: RV32I/RV64I integer ops plus optional
//  iterative M-extension multiply/divide. Sits in EX stage between operand read and writeback.
//  Results are registered and held until the consumer takes them; multi-cycle ops stall upstream via ready_o.
// PARAMETERS
//  WIDTH    32               operand/result width in bits (32 or 64)
//  SHAMT_W  $clog2(WIDTH)    shift-amount bits taken from b_i
// PORTS
//  clk_i      in   1      clock; all state updates on rising edge
//  reset_n_i  in   1      synchronous reset, active-low
//  v_i        in   1      request valid
//  ready_o    out  1      unit can accept request this cycle
//  a_i        in   WIDTH  operand A (rs1)
//  b_i        in   WIDTH  operand B (rs2/imm)
//  op_i       in   3      rvga_funct3 operation select
//  alt_i      in   1      funct7[5]: SUB / SRA
//  mul_i      in   1      funct7[0]: M-extension op
//  flush_i    in   1      abort any in-flight op; drop held result
//  v_o        out  1      result valid
//  ready_i    in   1      consumer takes result
//  res_o      out  WIDTH  result
//  illegal_o  out  1      qualifies v_o: op not supported in this build
// BEHAVIOUR
//  - Reset (reset_n_i=0 at edge): state=IDLE, v_o=0, res_o=0, illegal_o=0, engine regs cleared; in-flight op lost.
//  - States: IDLE -> (accept base op / M short-circuit) DONE; IDLE -> (accept M op) BUSY -> FIX -> DONE;
//    DONE -> (ready_i) IDLE, or DONE directly if a new request is accepted that same cycle.
//  - ready_o = (state==IDLE) | (state==DONE & ready_i); accept = v_i & ready_o & ~flush_i.
//  - v_o = (state==DONE); res_o, illegal_o stable while v_o=1 & ready_i=0.
//  - Base ops (mul_i=0): ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; result registered, v_o 1 cycle after accept.
//  - Shifts use b_i[SHAMT_W-1:0] only; upper bits ignored. SLT/SLTU zero-extend 1-bit result to WIDTH.
//  - M ops (op_i 0..7): MUL, MULH(s*s), MULHSU(s*u), MULHU, DIV, DIVU, REM, REMU.
//    Engine works on magnitudes: BUSY for exactly WIDTH cycles (radix-2 shift-add multiply into 2*WIDTH
//    accumulator / restoring divide, one bit per cycle), FIX 1 cycle applies sign; v_o at WIDTH+2 cycles after accept.
//  - Short-circuit (-> DONE, latency 1): divide by zero: DIV/DIVU = all ones, REM/REMU = a_i;
//    signed overflow (a_i = MIN, b_i = -1): DIV = MIN, REM = 0.
//  - REM sign follows dividend; DIV truncates toward zero. MUL returns low WIDTH bits; MULH* high WIDTH bits.
//  - flush_i: any state -> IDLE next edge, v_o=0, no result emitted; a request with flush_i=1 is not accepted.
//    flush_i while v_o & ready_i: flush wins, result counts as not taken (upstream replays).
//  - Reset and flush both dominate accept; reset dominates flush.
// CONFIGURATION
//  RVGA_XALU_MULDIV_EN defined: M ops executed as above, illegal_o always 0.
//  Not defined: engine and BUSY/FIX absent; mul_i=1 request -> DONE after 1 cycle, res_o=0, illegal_o=1.
// STRUCTURE
//  rvga_types package additions: rvga_mdop_e (e_rvga_mdop_mul..e_rvga_mdop_remu, aligned to funct3),
//  rvga_xalu_state_e {IDLE,BUSY,FIX,DONE}. Existing rvga_funct3/artop enums reused for base ops.
//  One sub-module: rvga_muldiv_iter (iterative magnitude mul/div engine: start, busy count, 2*WIDTH product /
//  quotient+remainder out), instantiated only under RVGA_XALU_MULDIV_EN; base ops and FIX sign logic in top.
// TESTING (WIDTH=32 unless noted)
//  1. SUB a=5 b=7 alt=1 -> res 0xFFFFFFFE, v_o 1 cycle after accept; SLT a=0xFFFFFFFF b=1 -> 1, SLTU -> 0.
//  2. SRA a=0x80000000 b=0x24 (shamt masked to 4) -> 0xF8000000; SRL same -> 0x08000000; repeat at WIDTH=64.
//  3. MULH a=0xFFFFFFFF b=2 -> 0xFFFFFFFF; MULHU -> 0x00000001; MULHSU -> 0xFFFFFFFF; MUL -> 0xFFFFFFFE;
//     each v_o exactly 34 cycles after accept, ready_o=0 throughout.
//  4. DIV 7/0 -> 0xFFFFFFFF, REM 7%0 -> 7, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, all latency 1;
//     DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
//  5. Hold ready_i=0 3 cycles on DONE -> res_o stable; drop ready_i with v_i high -> back-to-back accept;
//     flush_i at BUSY cycle 10 -> no v_o, ready_o=1 next cycle; reset_n_i=0 mid-BUSY -> all outputs 0.
//  6. Build without RVGA_XALU_MULDIV_EN: MUL 3*4 -> v_o after 1 cycle, res 0, illegal_o=1; base ops unchanged.

Source files
------------

// File: rtl/rvga_xalu_pkg.sv
// rvga_xalu_pkg: encodings shared by the rvga execute unit.
// Optional M extension enabled by RVGA_XALU_MULDIV_EN.
package rvga_xalu_pkg;

  typedef enum logic [2:0] {
    e_rvga_funct3_add  = 3'd0,
    e_rvga_funct3_sll  = 3'd1,
    e_rvga_funct3_slt  = 3'd2,
    e_rvga_funct3_sltu = 3'd3,
    e_rvga_funct3_xor  = 3'd4,
    e_rvga_funct3_sr   = 3'd5,
    e_rvga_funct3_or   = 3'd6,
    e_rvga_funct3_and  = 3'd7
  } rvga_funct3_e;

  typedef enum logic [2:0] {
    e_rvga_mdop_mul    = 3'd0,
    e_rvga_mdop_mulh   = 3'd1,
    e_rvga_mdop_mulhsu = 3'd2,
    e_rvga_mdop_mulhu  = 3'd3,
    e_rvga_mdop_div    = 3'd4,
    e_rvga_mdop_divu   = 3'd5,
    e_rvga_mdop_rem    = 3'd6,
    e_rvga_mdop_remu   = 3'd7
  } rvga_mdop_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } rvga_xalu_state_e;

endpackage

// File: rtl/rvga_muldiv_iter.sv
// rvga_muldiv_iter: radix-2 magnitude multiply / restoring divide,
// one bit per cycle for WIDTH cycles; acc_o = {hi, lo}.
module rvga_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               start_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] acc_o
);
  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic               div;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;

  assign done_o = busy & (cnt == CW'(WIDTH-1));
  assign acc_o  = acc;

  always_comb begin
    hi   = acc[2*WIDTH-1:WIDTH];
    lo   = acc[WIDTH-1:0];
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shl  = {hi, lo[WIDTH-1]};
    diff = shl - {1'b0, b};
    // lo doubles as multiplier shifting out / quotient shifting in
    if (div) begin
      if (diff[WIDTH])
        acc_d = {shl[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      else
        acc_d = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {sum, lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      busy <= 1'b0;
      div  <= 1'b0;
      cnt  <= '0;
      b    <= '0;
      acc  <= '0;
    end else if (flush_i) begin
      busy <= 1'b0;
    end else if (start_i) begin
      busy <= 1'b1;
      div  <= div_i;
      cnt  <= '0;
      b    <= b_i;
      acc  <= {{WIDTH{1'b0}}, a_i};
    end else if (busy) begin
      acc <= acc_d;
      cnt <= cnt + 1'b1;
      if (done_o) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rvga_xalu.sv
// rvga_xalu: handshaked EX unit, RV32I/RV64I ALU plus iterative
// M extension when RVGA_XALU_MULDIV_EN is defined.
module rvga_xalu
  import rvga_xalu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             v_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             alt_i,
  input  logic             mul_i,
  input  logic             flush_i,
  output logic             v_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             illegal_o
);
  rvga_xalu_state_e state, state_d;

  logic [WIDTH-1:0]        res;
  logic                    ill;
  logic                    accept;
  logic                    go_busy;
  logic                    eng_done;
  logic [WIDTH-1:0]        base_res;
  logic [WIDTH-1:0]        acc_res;
  logic                    acc_ill;
  logic [SHAMT_W-1:0]      shamt;
  logic signed [WIDTH-1:0] sra;

  assign ready_o   = (state == IDLE)
                   | ((state == DONE) & ready_i);
  assign accept    = v_i & ready_o & ~flush_i;
  assign v_o       = (state == DONE);
  assign res_o     = res;
  assign illegal_o = ill;

  always_comb begin
    shamt    = b_i[SHAMT_W-1:0];
    sra      = $signed(a_i) >>> shamt;
    base_res = '0;
    unique case (op_i)
      e_rvga_funct3_add:
        base_res = alt_i ? a_i - b_i : a_i + b_i;
      e_rvga_funct3_sll:
        base_res = a_i << shamt;
      e_rvga_funct3_slt:
        base_res = {{(WIDTH-1){1'b0}},
                    $signed(a_i) < $signed(b_i)};
      e_rvga_funct3_sltu:
        base_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
      e_rvga_funct3_xor:
        base_res = a_i ^ b_i;
      e_rvga_funct3_sr:
        base_res = alt_i ? sra : a_i >> shamt;
      e_rvga_funct3_or:
        base_res = a_i | b_i;
      e_rvga_funct3_and:
        base_res = a_i & b_i;
    endcase
  end

`ifdef RVGA_XALU_MULDIV_EN
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic               a_sgn, b_sgn, neg, neg_q;
  logic               dz, ovf, short;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   short_res, fix_res;
  logic [WIDTH-1:0]   quo, rem;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc, prod;

  always_comb begin
    a_sgn = a_i[WIDTH-1]
          & (op_i == e_rvga_mdop_mulh
           | op_i == e_rvga_mdop_mulhsu
           | op_i == e_rvga_mdop_div
           | op_i == e_rvga_mdop_rem);
    b_sgn = b_i[WIDTH-1]
          & (op_i == e_rvga_mdop_mulh
           | op_i == e_rvga_mdop_div
           | op_i == e_rvga_mdop_rem);
    a_mag = a_sgn ? -a_i : a_i;
    b_mag = b_sgn ? -b_i : b_i;
    // remainder takes the dividend's sign
    neg   = (op_i == e_rvga_mdop_rem) ? a_sgn
                                       : a_sgn ^ b_sgn;
    dz    = (b_i == '0);
    ovf   = (op_i == e_rvga_mdop_div
           | op_i == e_rvga_mdop_rem)
          & (a_i == MIN) & (&b_i);
    short = op_i[2] & (dz | ovf);
    if (dz)
      short_res = op_i[1] ? a_i : '1;
    else
      short_res = op_i[1] ? '0 : MIN;
    go_busy = mul_i & ~short;
    acc_res = mul_i ? short_res : base_res;
    acc_ill = 1'b0;
  end

  always_comb begin
    prod    = neg_q ? -acc : acc;
    quo     = acc[WIDTH-1:0];
    rem     = acc[2*WIDTH-1:WIDTH];
    fix_res = '0;
    unique case (op_q)
      e_rvga_mdop_mul:    fix_res = prod[WIDTH-1:0];
      e_rvga_mdop_mulh,
      e_rvga_mdop_mulhsu,
      e_rvga_mdop_mulhu:  fix_res = prod[2*WIDTH-1:WIDTH];
      e_rvga_mdop_div,
      e_rvga_mdop_divu:   fix_res = neg_q ? -quo : quo;
      e_rvga_mdop_rem,
      e_rvga_mdop_remu:   fix_res = neg_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      op_q  <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      op_q  <= op_i;
      neg_q <= neg;
    end
  end

  rvga_muldiv_iter #(.WIDTH(WIDTH)) engine (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush_i),
    .start_i   (accept & go_busy),
    .div_i     (op_i[2]),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .done_o    (eng_done),
    .acc_o     (acc)
  );
`else
  assign eng_done = 1'b0;

  always_comb begin
    go_busy = 1'b0;
    acc_res = mul_i ? '0 : base_res;
    acc_ill = mul_i;
  end
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: state_d = IDLE;
      BUSY: if (eng_done) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
    endcase
    if (accept) state_d = go_busy ? BUSY : DONE;
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      res   <= '0;
      ill   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        res <= acc_res;
        ill <= acc_ill;
      end
`ifdef RVGA_XALU_MULDIV_EN
      else if (state == FIX) begin
        res <= fix_res;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rvga_xalu.sv
// tb_rvga_xalu: vector table plus handshake scoreboard for rvga_xalu,
// with a WIDTH=64 instance for the wide shift cases.
module tb_rvga_xalu;
  localparam int LIM = 200;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        alt;
    logic        mul;
    logic [31:0] exp;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  logic        clk, rst_n;
  logic        v, v64, alt, mul, flush, ready;
  logic [31:0] a, b;
  logic [63:0] a64, b64;
  logic [2:0]  op;
  logic        rdy, vo, ill;
  logic [31:0] res;
  logic        rdy64, vo64, ill64;
  logic [63:0] res64;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[$];
  exp_t sb[$];

  rvga_xalu #(.WIDTH(32)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v),
    .ready_o(rdy), .a_i(a), .b_i(b), .op_i(op),
    .alt_i(alt), .mul_i(mul), .flush_i(flush),
    .v_o(vo), .ready_i(ready), .res_o(res),
    .illegal_o(ill)
  );

  rvga_xalu #(.WIDTH(64)) dut64 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v64),
    .ready_o(rdy64), .a_i(a64), .b_i(b64), .op_i(op),
    .alt_i(alt), .mul_i(mul), .flush_i(flush),
    .v_o(vo64), .ready_i(ready), .res_o(res64),
    .illegal_o(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void addv(
    input logic [31:0] ta, input logic [31:0] tb,
    input logic [2:0] top, input logic talt,
    input logic tmul, input logic [31:0] texp,
    input int tlat);
    vec_t t;
    t.a = ta; t.b = tb; t.op = top;
    t.alt = talt; t.mul = tmul;
    t.exp = texp; t.ill = 1'b0; t.lat = tlat;
`ifndef RVGA_XALU_MULDIV_EN
    if (tmul) begin
      t.exp = '0; t.ill = 1'b1; t.lat = 1;
    end
`endif
    tbl.push_back(t);
  endfunction

  // scoreboard: pop on every taken result
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && vo && ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_pop: stray result %h", res);
      end else begin
        e = sb.pop_front();
        chk("res", res, e.res);
        chk("ill", ill, e.ill);
      end
    end
  end

  task automatic run_op(input vec_t t);
    int   n;
    logic rseen;
    a = t.a; b = t.b; op = t.op;
    alt = t.alt; mul = t.mul;
    v = 1'b1; ready = 1'b1;
    #1;
    n = 0;
    while (!rdy && n < LIM) begin
      step();
      n++;
    end
    chk("accept", rdy, 1);
    sb.push_back(exp_t'{t.exp, t.ill});
    step();
    v = 1'b0; mul = 1'b0;
    n = 1; rseen = 1'b0;
    while (!vo && n < LIM) begin
      if (rdy) rseen = 1'b1;
      step();
      n++;
    end
    chk("latency", n, t.lat);
    chk("busy_ready", rseen, 0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; v = 0; v64 = 0; alt = 0; mul = 0;
    flush = 0; ready = 1; a = 0; b = 0;
    a64 = 0; b64 = 0; op = 0;
    repeat (3) step();
    chk("rst_v", vo, 0);
    chk("rst_res", res, 0);
    chk("rst_ill", ill, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", rdy, 1);

    // WIDTH=64 shifts and subtract
    op = 3'd5; alt = 1; v64 = 1;
    a64 = 64'h8000_0000_0000_0000; b64 = 64'h24;
    step();
    chk("w64_v", vo64, 1);
    chk("w64_sra", res64, 64'hFFFF_FFFF_F800_0000);
    alt = 0; b64 = 64'h64;
    step();
    chk("w64_srl", res64, 64'h0000_0000_0800_0000);
    op = 3'd0; alt = 1; a64 = 64'd5; b64 = 64'd7;
    step();
    chk("w64_sub", res64, 64'hFFFF_FFFF_FFFF_FFFE);
    v64 = 0; alt = 0;
    step();

    addv(32'd5, 32'd7, 3'd0, 1, 0, 32'hFFFF_FFFE, 1);
    addv(32'hFFFF_FFFF, 32'd1, 3'd2, 0, 0, 32'd1, 1);
    addv(32'hFFFF_FFFF, 32'd1, 3'd3, 0, 0, 32'd0, 1);
    addv(32'h8000_0000, 32'h24, 3'd5, 1, 0, 32'hF800_0000, 1);
    addv(32'h8000_0000, 32'h24, 3'd5, 0, 0, 32'h0800_0000, 1);
    addv(32'd1, 32'h3F, 3'd1, 0, 0, 32'h8000_0000, 1);
    addv(32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0, 32'd0, 1);
    addv(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 0, 0, 32'h0FF0_0FF0, 1);
    addv(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 0, 0, 32'hFFF0_FFF0, 1);
    addv(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 0, 0, 32'hF000_F000, 1);
    addv(32'hFFFF_FFFF, 32'd2, 3'd1, 0, 1, 32'hFFFF_FFFF, 34);
    addv(32'hFFFF_FFFF, 32'd2, 3'd3, 0, 1, 32'h0000_0001, 34);
    addv(32'hFFFF_FFFF, 32'd2, 3'd2, 0, 1, 32'hFFFF_FFFF, 34);
    addv(32'hFFFF_FFFF, 32'd2, 3'd0, 0, 1, 32'hFFFF_FFFE, 34);
    addv(32'd3, 32'd4, 3'd0, 0, 1, 32'd12, 34);
    addv(32'h8000_0000, 32'h8000_0000, 3'd1, 0, 1, 32'h4000_0000, 34);
    addv(32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 0, 1, 32'h8000_0000, 34);
    addv(32'd7, 32'd0, 3'd4, 0, 1, 32'hFFFF_FFFF, 1);
    addv(32'd7, 32'd0, 3'd6, 0, 1, 32'd7, 1);
    addv(32'd9, 32'd0, 3'd5, 0, 1, 32'hFFFF_FFFF, 1);
    addv(32'd9, 32'd0, 3'd7, 0, 1, 32'd9, 1);
    addv(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 0, 1, 32'h8000_0000, 1);
    addv(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 0, 1, 32'd0, 1);
    addv(32'hFFFF_FFF9, 32'd2, 3'd4, 0, 1, 32'hFFFF_FFFD, 34);
    addv(32'hFFFF_FFF9, 32'd2, 3'd6, 0, 1, 32'hFFFF_FFFF, 34);
    addv(32'd7, 32'hFFFF_FFFD, 3'd4, 0, 1, 32'hFFFF_FFFE, 34);
    addv(32'd7, 32'hFFFF_FFFD, 3'd6, 0, 1, 32'd1, 34);
    addv(32'd100, 32'd7, 3'd5, 0, 1, 32'd14, 34);
    addv(32'd100, 32'd7, 3'd7, 0, 1, 32'd2, 34);
    addv(32'h8000_0000, 32'hFFFF_FFFF, 3'd5, 0, 1, 32'd0, 34);
    addv(32'h8000_0000, 32'hFFFF_FFFF, 3'd7, 0, 1, 32'h8000_0000, 34);
    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);
    step();

    // hold result, then back-to-back accept from DONE
    sb.push_back(exp_t'{32'hFFFF_FFFE, 1'b0});
    a = 32'd5; b = 32'd7; op = 3'd0; alt = 1;
    v = 1; ready = 0;
    step();
    v = 0; alt = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_v", vo, 1);
      chk("hold_res", res, 32'hFFFF_FFFE);
      step();
    end
    a = 32'd2; b = 32'd3; v = 1; ready = 1;
    sb.push_back(exp_t'{32'd5, 1'b0});
    #1;
    chk("b2b_ready", rdy, 1);
    step();
    v = 0;
    chk("b2b_v", vo, 1);
    step();

    // flush while a result is offered
    a = 32'd1; b = 32'd1; v = 1; ready = 0;
    step();
    v = 0;
    chk("fl_pre_v", vo, 1);
    flush = 1; ready = 1;
    step();
    flush = 0;
    chk("fl_drop_v", vo, 0);

    // a request under flush is refused
    v = 1; flush = 1;
    step();
    v = 0; flush = 0;
    chk("fl_req_v", vo, 0);
    chk("fl_req_rdy", rdy, 1);

`ifdef RVGA_XALU_MULDIV_EN
    // flush in BUSY cycle 10
    a = 32'd100; b = 32'd7; op = 3'd5; mul = 1; v = 1;
    step();
    v = 0; mul = 0;
    repeat (9) step();
    chk("busy_rdy", rdy, 0);
    flush = 1;
    step();
    flush = 0;
    chk("flb_v", vo, 0);
    chk("flb_rdy", rdy, 1);
    seen = 1'b0;
    repeat (40) begin
      if (vo) seen = 1'b1;
      step();
    end
    chk("flb_silent", seen, 0);
`endif

    // reset while busy (or while holding an illegal result)
    a = 32'd3; b = 32'd4; op = 3'd0; mul = 1;
    v = 1; ready = 0;
    step();
    v = 0; mul = 0;
    repeat (4) step();
    rst_n = 0;
    step();
    chk("mrst_v", vo, 0);
    chk("mrst_res", res, 0);
    chk("mrst_ill", ill, 0);
    rst_n = 1; ready = 1;
    step();

    // engine still works after flush and reset
    tbl.delete();
    addv(32'd100, 32'd7, 3'd7, 0, 1, 32'd2, 34);
    addv(32'd6, 32'd7, 3'd0, 0, 0, 32'd13, 1);
    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
